phase_timer: RTL

- Receiving end of the 1 Hz slowed_clk produced by the frequency divider.
- Resynchronises that square wave into the fast clk domain and converts each rising edge into a single-cycle sec_tick.
- Runs a loadable seconds countdown for traffic-light phase durations (green/yellow/red), with an expiry pulse for the controller FSM.
- Watchdog flags a stalled or missing slowed_clk.

---
 rtl/phase_timer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : Resynchronises the 1 Hz slowed_clk into clk, emits sec_tick, runs
//            a loadable seconds countdown and flags a missing slowed_clk.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH     = 8,
    parameter int FREQUENCY = 100000000,
    parameter int TIMEOUT   = FREQUENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slowed_clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             hold,
    output logic             sec_tick,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             expired,
    output logic             tick_lost
);

    localparam int               WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    logic s1_q, s2_q, s3_q;
    logic tick_q;
    logic w_edge;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            lost_q, lost_d;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic            exp_q, exp_d;

    // s1 may go metastable; s2/s3 are the clean pair used for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            s1_q   <= slowed_clk;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            tick_q <= s2_q & ~s3_q;
        end
    end

    assign w_edge = s2_q ^ s3_q;

    always_comb begin
        wd_d = wd_q;
        if (w_edge) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
        end
        lost_d = lost_q | (wd_d == WD_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q   <= '0;
            lost_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            lost_q <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    if (load_value != '0) begin
                        rem_d   = load_value;
                        state_d = ST_COUNT;
                    end else begin
                        rem_d = '0;
                        exp_d = 1'b1;
                    end
                end
            end
            ST_COUNT: begin
                // load beats hold beats tick; a tick under hold is simply dropped
                if (load) begin
                    if (load_value != '0) begin
                        rem_d = load_value;
                    end else begin
                        rem_d   = '0;
                        exp_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (!hold && tick_q) begin
                    if (rem_q <= ONE) begin
                        rem_d   = '0;
                        exp_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d = rem_q - ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
        end
    end

    assign sec_tick  = tick_q;
    assign remaining = rem_q;
    assign busy      = (state_q == ST_COUNT);
    assign expired   = exp_q;
    assign tick_lost = lost_q;

endmodule
`default_nettype wire
